exc_capture_unit: RTL and testbench

- Execute-stage exception capture block, directly downstream of the ALU.
- Consumes the ALU 8-bit status byte, the ALU result and the EX-stage control flags.
- Detects divide-by-zero, signed overflow and misaligned word access, then latches EPC, cause and bad address.
- Drives a stall/req/ack handshake with the main controller, followed by a one-cycle pipeline flush.

---
 rtl/exc_capture_unit_pkg.sv | 32 +++
 rtl/exc_capture_unit_priority_enc.sv | 42 ++++
 rtl/exc_capture_unit.sv | 159 +++++++++++++++
 tb/tb_exc_capture_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_capture_unit_pkg.sv
// Shared definitions for the execute-stage exception capture block:
// cause codes, ALU status bit positions and the FSM state encoding.
package exc_capture_unit_pkg;

  // Cause codes reported on EXC_cause
  localparam logic [3:0] CAUSE_NONE = 4'h0;
  localparam logic [3:0] CAUSE_ADEL = 4'h4;
  localparam logic [3:0] CAUSE_ADES = 4'h5;
  localparam logic [3:0] CAUSE_OV   = 4'hC;
  localparam logic [3:0] CAUSE_DIVZ = 4'hF;

  // Bit positions inside the ALU status byte
  localparam int ST_ZERO  = 7;
  localparam int ST_OVF   = 6;
  localparam int ST_CARRY = 5;
  localparam int ST_NEG   = 4;
  localparam int ST_ADDR  = 3;
  localparam int ST_DIVZ  = 2;

  // Capture/handshake FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    FLUSH = 2'b10
  } exc_state_e;

  // Address-error causes are the only ones that record a bad address
  function automatic logic is_addr_cause(input logic [3:0] cause);
    return (cause == CAUSE_ADEL) || (cause == CAUSE_ADES);
  endfunction

endpackage

// File: rtl/exc_capture_unit_priority_enc.sv
// exc_priority_enc: combinational trap detector and cause encoder.
// Priority, highest first: divide-by-zero, trapping overflow,
// misaligned load, misaligned store. A load wins over a store when both
// flags are set. Nothing is reported unless the instruction is valid.
import exc_capture_unit_pkg::*;

module exc_priority_enc (
  input  logic       valid,
  input  logic [7:0] status,
  input  logic       ovf_trap,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       trap,
  output logic [3:0] cause
);

  // Zero, carry, negative and the two reserved bits take no part in trapping
  logic unused_status;
  assign unused_status = ^{status[ST_ZERO], status[ST_CARRY], status[ST_NEG], status[1:0]};

  // Priority chain; the first matching condition selects the cause
  always_comb begin
    trap  = 1'b0;
    cause = CAUSE_NONE;
    if (valid) begin
      if (status[ST_DIVZ]) begin
        trap  = 1'b1;
        cause = CAUSE_DIVZ;
      end else if (status[ST_OVF] && ovf_trap) begin
        trap  = 1'b1;
        cause = CAUSE_OV;
      end else if (status[ST_ADDR] && mem_read) begin
        trap  = 1'b1;
        cause = CAUSE_ADEL;
      end else if (status[ST_ADDR] && mem_write) begin
        trap  = 1'b1;
        cause = CAUSE_ADES;
      end
    end
  end

endmodule

// File: rtl/exc_capture_unit.sv
// exc_capture_unit: execute-stage exception capture and handshake.
// Latches EPC/cause/bad address on a trap, holds the pipeline with a
// req/stall until the controller acks, then squashes with a one-cycle
// flush. Optional trap counter enabled by defining EXC_COUNT_EN.
//
// state | meaning
// IDLE  | watching the EX stage, capture on the first trap
// REQ   | exception pending, pipeline stalled, waiting for EXC_ack
// FLUSH | one-cycle squash of IF/ID/EX, traps in this cycle are dropped
import exc_capture_unit_pkg::*;

module exc_capture_unit #(
  parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180,
  parameter int          COUNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXC_valid,
  input  logic [31:0] EXC_pc,
  input  logic [7:0]  EXC_status,
  input  logic [31:0] EXC_alu_result,
  input  logic        EXC_ovf_trap,
  input  logic        EXC_mem_read,
  input  logic        EXC_mem_write,
  input  logic        EXC_ack,
  output logic        EXC_req,
  output logic        EXC_stall,
  output logic        EXC_flush,
  output logic [31:0] EXC_epc,
  output logic [3:0]  EXC_cause,
  output logic [31:0] EXC_badvaddr,
  output logic [31:0] EXC_vector
`ifdef EXC_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] EXC_trap_count
`endif
);

  exc_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic [31:0] epc_q, epc_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        trap;
  logic [3:0]  trap_cause;
  logic        capture;

  exc_priority_enc u_prio (
    .valid     (EXC_valid),
    .status    (EXC_status),
    .ovf_trap  (EXC_ovf_trap),
    .mem_read  (EXC_mem_read),
    .mem_write (EXC_mem_write),
    .trap      (trap),
    .cause     (trap_cause)
  );

  // A trap is only taken from IDLE; REQ and FLUSH ignore the EX stage
  assign capture = (state_q == IDLE) && trap;

  // Next state, next registered outputs and capture registers
  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    epc_d      = epc_q;
    cause_d    = cause_q;
    badvaddr_d = badvaddr_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          epc_d   = EXC_pc;
          cause_d = trap_cause;
          if (is_addr_cause(trap_cause)) begin
            badvaddr_d = EXC_alu_result;
          end
          state_d = REQ;
          req_d   = 1'b1;
          stall_d = 1'b1;
        end
      end
      REQ: begin
        if (EXC_ack) begin
          state_d = FLUSH;
          flush_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          stall_d = 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; outputs are computed alongside the
  // next state so they always match the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
      epc_q      <= 32'h0;
      cause_q    <= CAUSE_NONE;
      badvaddr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign EXC_req      = req_q;
  assign EXC_stall    = stall_q;
  assign EXC_flush    = flush_q;
  assign EXC_epc      = epc_q;
  assign EXC_cause    = cause_q;
  assign EXC_badvaddr = badvaddr_q;
  assign EXC_vector   = VECTOR_ADDR;

`ifdef EXC_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Saturating count of accepted traps (IDLE->REQ transitions)
  always_comb begin
    count_d = count_q;
    if (capture && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Trap counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign EXC_trap_count = count_q;
`else
  localparam int unused_count_width = COUNT_WIDTH;
`endif

endmodule

// File: tb/tb_exc_capture_unit.sv
// Directed bench for exc_capture_unit. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.
module tb_exc_capture_unit;

  logic        clk;
  logic        rst;
  logic        EXC_valid;
  logic [31:0] EXC_pc;
  logic [7:0]  EXC_status;
  logic [31:0] EXC_alu_result;
  logic        EXC_ovf_trap;
  logic        EXC_mem_read;
  logic        EXC_mem_write;
  logic        EXC_ack;
  logic        EXC_req;
  logic        EXC_stall;
  logic        EXC_flush;
  logic [31:0] EXC_epc;
  logic [3:0]  EXC_cause;
  logic [31:0] EXC_badvaddr;
  logic [31:0] EXC_vector;
`ifdef EXC_COUNT_EN
  logic [1:0]  EXC_trap_count;
`endif

  int checks = 0;
  int errors = 0;

`ifdef EXC_COUNT_EN
  exc_capture_unit #(.COUNT_WIDTH(2)) dut (
`else
  exc_capture_unit dut (
`endif
    .clk            (clk),
    .rst            (rst),
    .EXC_valid      (EXC_valid),
    .EXC_pc         (EXC_pc),
    .EXC_status     (EXC_status),
    .EXC_alu_result (EXC_alu_result),
    .EXC_ovf_trap   (EXC_ovf_trap),
    .EXC_mem_read   (EXC_mem_read),
    .EXC_mem_write  (EXC_mem_write),
    .EXC_ack        (EXC_ack),
    .EXC_req        (EXC_req),
    .EXC_stall      (EXC_stall),
    .EXC_flush      (EXC_flush),
    .EXC_epc        (EXC_epc),
    .EXC_cause      (EXC_cause),
    .EXC_badvaddr   (EXC_badvaddr),
    .EXC_vector     (EXC_vector)
`ifdef EXC_COUNT_EN
    ,
    .EXC_trap_count (EXC_trap_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    EXC_valid      = 1'b0;
    EXC_pc         = 32'h0;
    EXC_status     = 8'h00;
    EXC_alu_result = 32'h0;
    EXC_ovf_trap   = 1'b0;
    EXC_mem_read   = 1'b0;
    EXC_mem_write  = 1'b0;
    EXC_ack        = 1'b0;
  endtask

  task automatic apply(input logic [7:0] st, input logic [31:0] pc, input logic [31:0] alu,
                       input logic ovf, input logic rd, input logic wr);
    EXC_valid      = 1'b1;
    EXC_status     = st;
    EXC_pc         = pc;
    EXC_alu_result = alu;
    EXC_ovf_trap   = ovf;
    EXC_mem_read   = rd;
    EXC_mem_write  = wr;
  endtask

  // Ack for one cycle from REQ, pass through FLUSH, end back in IDLE
  task automatic finish_handshake();
    EXC_ack = 1'b1;
    tick();
    EXC_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (EXC_req !== 1'b0 || EXC_stall !== 1'b0 || EXC_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b stall=%b flush=%b want 0 0 0", EXC_req, EXC_stall, EXC_flush);
    end
    checks++;
    if (EXC_epc !== 32'h0 || EXC_cause !== 4'h0 || EXC_badvaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got epc=%h cause=%h bad=%h want zeros", EXC_epc, EXC_cause, EXC_badvaddr);
    end
    checks++;
    if (EXC_vector !== 32'h8000_0180) begin
      errors++;
      $display("FAIL vector got %h want 80000180", EXC_vector);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divz();
    apply(8'h84, 32'h0040_0010, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b1 || EXC_stall !== 1'b1 || EXC_flush !== 1'b0) begin
      errors++;
      $display("FAIL divz_req got req=%b stall=%b flush=%b want 1 1 0", EXC_req, EXC_stall, EXC_flush);
    end
    checks++;
    if (EXC_cause !== 4'hF || EXC_epc !== 32'h0040_0010) begin
      errors++;
      $display("FAIL divz_capture got cause=%h epc=%h want f 00400010", EXC_cause, EXC_epc);
    end
    tick();
    tick();
    EXC_ack = 1'b1;
    tick();
    EXC_ack = 1'b0;
    checks++;
    if (EXC_flush !== 1'b1 || EXC_req !== 1'b0 || EXC_stall !== 1'b0) begin
      errors++;
      $display("FAIL divz_flush got flush=%b req=%b stall=%b want 1 0 0", EXC_flush, EXC_req, EXC_stall);
    end
    tick();
    checks++;
    if (EXC_flush !== 1'b0 || EXC_req !== 1'b0) begin
      errors++;
      $display("FAIL divz_after got flush=%b req=%b want 0 0", EXC_flush, EXC_req);
    end
    checks++;
    if (EXC_cause !== 4'hF || EXC_epc !== 32'h0040_0010) begin
      errors++;
      $display("FAIL divz_hold got cause=%h epc=%h want f 00400010", EXC_cause, EXC_epc);
    end
  endtask

  task automatic test_store();
    apply(8'h08, 32'h0040_0020, 32'h1000_0002, 1'b0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b1 || EXC_cause !== 4'h5 || EXC_badvaddr !== 32'h1000_0002 || EXC_epc !== 32'h0040_0020) begin
      errors++;
      $display("FAIL ades got req=%b cause=%h bad=%h epc=%h want 1 5 10000002 00400020",
               EXC_req, EXC_cause, EXC_badvaddr, EXC_epc);
    end
    finish_handshake();
    apply(8'h08, 32'h0040_0024, 32'h2000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b0 || EXC_badvaddr !== 32'h1000_0002) begin
      errors++;
      $display("FAIL addr_noflags got req=%b bad=%h want 0 10000002", EXC_req, EXC_badvaddr);
    end
    apply(8'h08, 32'h0040_0028, 32'h3000_0003, 1'b0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b1 || EXC_cause !== 4'h4 || EXC_badvaddr !== 32'h3000_0003) begin
      errors++;
      $display("FAIL adel_wins got req=%b cause=%h bad=%h want 1 4 30000003", EXC_req, EXC_cause, EXC_badvaddr);
    end
    finish_handshake();
  endtask

  task automatic test_priority();
    apply(8'h4C, 32'h0040_0030, 32'h5555_0000, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (EXC_cause !== 4'hF || EXC_badvaddr !== 32'h3000_0003) begin
      errors++;
      $display("FAIL prio_divz got cause=%h bad=%h want f 30000003", EXC_cause, EXC_badvaddr);
    end
    finish_handshake();
    apply(8'h48, 32'h0040_0034, 32'h6666_0000, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (EXC_cause !== 4'hC || EXC_epc !== 32'h0040_0034 || EXC_badvaddr !== 32'h3000_0003) begin
      errors++;
      $display("FAIL prio_ov got cause=%h epc=%h bad=%h want c 00400034 30000003",
               EXC_cause, EXC_epc, EXC_badvaddr);
    end
    finish_handshake();
    apply(8'hF3 & 8'hFB, 32'h0040_0038, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b0 || EXC_cause !== 4'hC) begin
      errors++;
      $display("FAIL ovf_no_trap got req=%b cause=%h want 0 c", EXC_req, EXC_cause);
    end
    apply(8'h04, 32'h0040_003C, 32'h0, 1'b0, 1'b0, 1'b0);
    EXC_valid = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b0 || EXC_epc !== 32'h0040_0034) begin
      errors++;
      $display("FAIL invalid_no_trap got req=%b epc=%h want 0 00400034", EXC_req, EXC_epc);
    end
  endtask

  task automatic test_held();
    int stall_drops;
    stall_drops = 0;
    apply(8'h04, 32'h0040_0100, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(8'h4C, 32'h0040_0200, 32'h7777_0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (EXC_stall !== 1'b1 || EXC_req !== 1'b1) stall_drops++;
    end
    idle_inputs();
    checks++;
    if (stall_drops != 0) begin
      errors++;
      $display("FAIL held_stall got %0d cycles without req/stall want 0", stall_drops);
    end
    checks++;
    if (EXC_epc !== 32'h0040_0100 || EXC_cause !== 4'hF) begin
      errors++;
      $display("FAIL held_regs got epc=%h cause=%h want 00400100 f", EXC_epc, EXC_cause);
    end
    finish_handshake();
    EXC_ack = 1'b1;
    tick();
    tick();
    EXC_ack = 1'b0;
    checks++;
    if (EXC_req !== 1'b0 || EXC_flush !== 1'b0 || EXC_stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack got req=%b flush=%b stall=%b want 0 0 0", EXC_req, EXC_flush, EXC_stall);
    end
  endtask

  task automatic test_back_to_back();
    apply(8'h40, 32'h0040_0300, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    EXC_ack = 1'b1;
    apply(8'h04, 32'h0040_0304, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    EXC_ack = 1'b0;
    checks++;
    if (EXC_flush !== 1'b1 || EXC_req !== 1'b0) begin
      errors++;
      $display("FAIL fast_ack got flush=%b req=%b want 1 0", EXC_flush, EXC_req);
    end
    apply(8'h04, 32'h0040_0308, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (EXC_req !== 1'b0 || EXC_flush !== 1'b0 || EXC_epc !== 32'h0040_0300 || EXC_cause !== 4'hC) begin
      errors++;
      $display("FAIL flush_ignores got req=%b flush=%b epc=%h cause=%h want 0 0 00400300 c",
               EXC_req, EXC_flush, EXC_epc, EXC_cause);
    end
    apply(8'h04, 32'h0040_030C, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b1 || EXC_epc !== 32'h0040_030C || EXC_cause !== 4'hF) begin
      errors++;
      $display("FAIL next_capture got req=%b epc=%h cause=%h want 1 0040030c f", EXC_req, EXC_epc, EXC_cause);
    end
    finish_handshake();
  endtask

  task automatic test_async_reset();
    apply(8'h04, 32'h0040_0400, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (EXC_req !== 1'b0 || EXC_stall !== 1'b0 || EXC_cause !== 4'h0 || EXC_epc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got req=%b stall=%b cause=%h epc=%h want 0 0 0 0",
               EXC_req, EXC_stall, EXC_cause, EXC_epc);
    end
    tick();
    rst = 1'b0;
    apply(8'h00, 32'h0040_0404, 32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (EXC_req !== 1'b0 || EXC_cause !== 4'h0) begin
      errors++;
      $display("FAIL post_reset got req=%b cause=%h want 0 0", EXC_req, EXC_cause);
    end
  endtask

`ifdef EXC_COUNT_EN
  task automatic test_count();
    logic [1:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (EXC_trap_count !== 2'd0) begin
      errors++;
      $display("FAIL count_reset got %0d want 0", EXC_trap_count);
    end
    for (int i = 0; i < 5; i++) begin
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      apply(8'h04, 32'h0040_0500, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      idle_inputs();
      checks++;
      if (EXC_trap_count !== want) begin
        errors++;
        $display("FAIL count_%0d got %0d want %0d", i, EXC_trap_count, want);
      end
      finish_handshake();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divz();
    test_store();
    test_priority();
    test_held();
    test_back_to_back();
    test_async_reset();
`ifdef EXC_COUNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
